// File: rtl/cpu_boot_ctl_if.sv
// Request/status bundle between the board support logic, cpu_boot_ctl and the core.
// master = support/core side, slave = cpu_boot_ctl.
interface cpu_boot_ctl_if;
  logic       reset_req;
  logic       boot_req;
  logic       halt_req;
  logic       boot_done;
  logic       core_reset;
  logic       prom_enable;
  logic       run;
  logic       halted;
  logic       boot_fail;
  logic [2:0] state;

  modport master (
    output reset_req, boot_req, halt_req, boot_done,
    input  core_reset, prom_enable, run, halted, boot_fail, state
  );

  modport slave (
    input  reset_req, boot_req, halt_req, boot_done,
    output core_reset, prom_enable, run, halted, boot_fail, state
  );
endinterface

// File: rtl/cpu_boot_ctl.sv
// CPU-side boot sequencer: sync + glitch-qualify reset/boot/halt requests, then walk RESET/BOOT/RUN/HALT.
// Optional boot watchdog (and the FAIL state) compiled in with CPU_BOOT_WATCHDOG_EN.
module cpu_boot_req_qual #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_REQ     = 4
) (
  input  logic cpuclk,
  input  logic reset_n,
  input  logic req_a,
  output logic req_q
);
  localparam logic [7:0] MIN_CNT = 8'(MIN_REQ);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [7:0]             cnt_r;
  logic                   q_r;
  logic                   req_s;

  assign req_s = sync_r[SYNC_STAGES-1];
  assign req_q = q_r;

  // Level only flips after MIN_REQ consecutive cycles disagreeing with it.
  always_ff @(posedge cpuclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
      cnt_r  <= '0;
      q_r    <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], req_a};
      if (req_s == q_r) begin
        cnt_r <= '0;
      end else if (cnt_r + 8'd1 == MIN_CNT) begin
        q_r   <= ~q_r;
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + 8'd1;
      end
    end
  end
endmodule

module cpu_boot_ctl #(
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_REQ      = 4,
  parameter int RESET_CYCLES = 16,
  parameter int BOOT_TIMEOUT = 1023
) (
  input  logic         cpuclk,
  input  logic         reset_n,
  cpu_boot_ctl_if.slave bus
);
  localparam int         NUM_REQ   = 3;
  localparam logic [15:0] RESET_CNT = 16'(RESET_CYCLES);

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_BOOT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  state_t               state_r, state_nxt;
  logic [NUM_REQ-1:0]   req_a, req_q;
  logic                 reset_q, boot_q, halt_q;
  logic                 reset_q_d, reset_rise;
  logic [15:0]          rst_cnt;
  logic                 wd_expired;

  assign req_a = {bus.halt_req, bus.boot_req, bus.reset_req};

  cpu_boot_req_qual #(
    .SYNC_STAGES (SYNC_STAGES),
    .MIN_REQ     (MIN_REQ)
  ) u_qual [NUM_REQ-1:0] (
    .cpuclk  (cpuclk),
    .reset_n (reset_n),
    .req_a   (req_a),
    .req_q   (req_q)
  );

  assign reset_q    = req_q[0];
  assign boot_q     = req_q[1];
  assign halt_q     = req_q[2];
  assign reset_rise = reset_q & ~reset_q_d;

  always_ff @(posedge cpuclk or negedge reset_n) begin
    if (!reset_n) reset_q_d <= 1'b0;
    else          reset_q_d <= reset_q;
  end

  // Outside RESET the count sits at 0, so every entry starts from zero.
  always_ff @(posedge cpuclk or negedge reset_n) begin
    if (!reset_n)                            rst_cnt <= '0;
    else if (reset_q || state_r != ST_RESET) rst_cnt <= '0;
    else if (rst_cnt != RESET_CNT)           rst_cnt <= rst_cnt + 16'd1;
  end

`ifdef CPU_BOOT_WATCHDOG_EN
  localparam logic [10:0] WD_LIMIT = 11'(BOOT_TIMEOUT);
  logic [10:0] wd_cnt;

  always_ff @(posedge cpuclk or negedge reset_n) begin
    if (!reset_n)               wd_cnt <= '0;
    else if (state_r != ST_BOOT) wd_cnt <= '0;
    else                        wd_cnt <= wd_cnt + 11'd1;
  end

  assign wd_expired = (wd_cnt == WD_LIMIT);
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge cpuclk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_RESET;
    else          state_r <= state_nxt;
  end

  always_comb begin
    state_nxt = state_r;
    if (reset_rise) begin
      state_nxt = ST_RESET;
    end else begin
      case (state_r)
        ST_RESET: if (rst_cnt == RESET_CNT && !reset_q && boot_q) state_nxt = ST_BOOT;
        ST_BOOT: begin
          if (bus.boot_done)   state_nxt = ST_RUN;
          else if (wd_expired) state_nxt = ST_FAIL;
        end
        ST_RUN:  if (halt_q)  state_nxt = ST_HALT;
        ST_HALT: if (!halt_q) state_nxt = ST_RUN;
        ST_FAIL: state_nxt = ST_FAIL;
        default: state_nxt = ST_RESET;
      endcase
    end
  end

  // Moore decode straight off the state register.
  always_comb begin
    bus.core_reset  = 1'b0;
    bus.prom_enable = 1'b0;
    bus.run         = 1'b0;
    bus.halted      = 1'b0;
    case (state_r)
      ST_RESET: bus.core_reset = 1'b1;
      ST_BOOT: begin
        bus.prom_enable = 1'b1;
        bus.run         = 1'b1;
      end
      ST_RUN:  bus.run        = 1'b1;
      ST_HALT: bus.halted     = 1'b1;
      ST_FAIL: bus.core_reset = 1'b1;
      default: bus.core_reset = 1'b1;
    endcase
  end

`ifdef CPU_BOOT_WATCHDOG_EN
  assign bus.boot_fail = (state_r == ST_FAIL);
`else
  assign bus.boot_fail = 1'b0;
`endif

  assign bus.state = state_r;
endmodule

// File: tb/tb_cpu_boot_ctl.sv
// Directed bench for cpu_boot_ctl with default parameters; watchdog steps follow CPU_BOOT_WATCHDOG_EN.
module tb_cpu_boot_ctl;
  // {core_reset, prom_enable, run, halted, boot_fail, state[2:0]}
  localparam logic [7:0] O_RESET = 8'b10000_000;
  localparam logic [7:0] O_BOOT  = 8'b01100_001;
  localparam logic [7:0] O_RUN   = 8'b00100_010;
  localparam logic [7:0] O_HALT  = 8'b00010_011;
  localparam logic [7:0] O_FAIL  = 8'b10001_100;

  logic cpuclk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  cpu_boot_ctl_if bus ();

  cpu_boot_ctl #(
    .SYNC_STAGES  (2),
    .MIN_REQ      (4),
    .RESET_CYCLES (16),
    .BOOT_TIMEOUT (1023)
  ) dut (
    .cpuclk  (cpuclk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial begin
    cpuclk = 1'b0;
    forever #5 cpuclk = ~cpuclk;
  end

  function automatic logic [7:0] outs();
    return {bus.core_reset, bus.prom_enable, bus.run, bus.halted, bus.boot_fail, bus.state};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge cpuclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // From RUN: a 4-cycle reset_req pulse gives RESET at edge 7 and BOOT at edge 27.
  task automatic reset_pulse(input string tag);
    bus.reset_req = 1'b1;
    tick(4);
    bus.reset_req = 1'b0;
    tick(2);
    chk({tag, "_e6"}, outs(), O_RUN);
    tick(1);
    chk({tag, "_e7"}, outs(), O_RESET);
    tick(19);
    chk({tag, "_e26"}, outs(), O_RESET);
    tick(1);
    chk({tag, "_e27"}, outs(), O_BOOT);
  endtask

  initial begin
    bus.reset_req = 1'b0;
    bus.boot_req  = 1'b1;
    bus.halt_req  = 1'b0;
    bus.boot_done = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 chk("rst_async", outs(), O_RESET);
    tick(3);
    chk("rst_hold", outs(), O_RESET);
    reset_n = 1'b1;

    // Power-up: BOOT on the 17th edge after release
    tick(16);
    chk("pwr_e16", outs(), O_RESET);
    tick(1);
    chk("pwr_e17", outs(), O_BOOT);

    // Boot handshake 50 cycles into BOOT, then a stray boot_done in RUN
    tick(49);
    chk("boot_wait", outs(), O_BOOT);
    bus.boot_done = 1'b1;
    tick(1);
    bus.boot_done = 1'b0;
    chk("boot_done", outs(), O_RUN);
    tick(5);
    bus.boot_done = 1'b1;
    tick(1);
    bus.boot_done = 1'b0;
    tick(1);
    chk("done_in_run", outs(), O_RUN);

    // 3-cycle glitch rejected
    bus.reset_req = 1'b1;
    tick(3);
    bus.reset_req = 1'b0;
    tick(4);
    chk("glitch_e7", outs(), O_RUN);
    tick(6);
    chk("glitch_e13", outs(), O_RUN);

    reset_pulse("rst4");
    bus.boot_done = 1'b1;
    tick(1);
    bus.boot_done = 1'b0;
    chk("boot2", outs(), O_RUN);

    // Halt 10 cycles, released 7 edges later
    bus.halt_req = 1'b1;
    tick(6);
    chk("halt_e6", outs(), O_RUN);
    tick(1);
    chk("halt_e7", outs(), O_HALT);
    tick(3);
    bus.halt_req = 1'b0;
    tick(6);
    chk("unhalt_e6", outs(), O_HALT);
    tick(1);
    chk("unhalt_e7", outs(), O_RUN);

    // boot_req dropping in RUN does nothing
    bus.boot_req = 1'b0;
    tick(10);
    chk("bootq_fall", outs(), O_RUN);
    bus.boot_req = 1'b1;
    tick(10);

    // reset_req held high: one re-entry, counter waits for the fall
    bus.reset_req = 1'b1;
    tick(7);
    chk("held_e7", outs(), O_RESET);
    tick(30);
    chk("held_e37", outs(), O_RESET);
    bus.reset_req = 1'b0;
    tick(22);
    chk("held_rel22", outs(), O_RESET);
    tick(1);
    chk("held_rel23", outs(), O_BOOT);

    // halt_q ignored in BOOT; boot_done on the watchdog-expiry cycle wins, then HALT
    bus.halt_req = 1'b1;
    tick(10);
    chk("halt_in_boot", outs(), O_BOOT);
    tick(1013);
    chk("boot_1023", outs(), O_BOOT);
    bus.boot_done = 1'b1;
    tick(1);
    bus.boot_done = 1'b0;
    chk("simul_run", outs(), O_RUN);
    tick(1);
    chk("simul_halt", outs(), O_HALT);
    bus.halt_req = 1'b0;
    tick(7);
    chk("simul_unhalt", outs(), O_RUN);

    reset_pulse("rst4b");
`ifdef CPU_BOOT_WATCHDOG_EN
    tick(1023);
    chk("wd_1023", outs(), O_BOOT);
    tick(1);
    chk("wd_fail", outs(), O_FAIL);
    bus.boot_done = 1'b1;
    tick(1);
    bus.boot_done = 1'b0;
    tick(1);
    chk("fail_done", outs(), O_FAIL);
    bus.reset_req = 1'b1;
    tick(4);
    bus.reset_req = 1'b0;
    tick(2);
    chk("fail_e6", outs(), O_FAIL);
    tick(1);
    chk("fail_e7", outs(), O_RESET);
    tick(20);
    chk("fail_boot", outs(), O_BOOT);
`else
    tick(5000);
    chk("no_wd_boot", outs(), O_BOOT);
`endif

    // Mid-run reset_n with a halt request in flight
    bus.boot_done = 1'b1;
    tick(1);
    bus.boot_done = 1'b0;
    chk("boot3", outs(), O_RUN);
    bus.halt_req = 1'b1;
    tick(4);
    reset_n = 1'b0;
    bus.halt_req = 1'b0;
    bus.boot_req = 1'b0;
    #1 chk("midrst_async", outs(), O_RESET);
    tick(2);
    reset_n = 1'b1;
    tick(30);
    chk("no_boot_q", outs(), O_RESET);
    bus.boot_req = 1'b1;
    tick(6);
    chk("sat_e6", outs(), O_RESET);
    tick(1);
    chk("sat_e7", outs(), O_BOOT);
    bus.boot_done = 1'b1;
    tick(1);
    bus.boot_done = 1'b0;
    tick(10);
    chk("no_pending", outs(), O_RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
